// File: rtl/way_refill_arbiter.sv
// way_refill_arbiter: round-robin fetch arbiter that refills empty merge-tree ways
// Optional feature: define WAY_REFILL_ARBITER_STAT_EN to add the o_refill_cnt refill counter
module way_refill_arbiter #(
  parameter int W_LOG = 6,
  parameter int P_LOG = 3,
  parameter int DATW  = 64,
  parameter int Q_LOG = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [(1<<W_LOG)-1:0]     i_emp,
  input  logic                      i_flush,
  output logic                      o_req_valid,
  output logic [W_LOG-1:0]          o_req_idx,
  input  logic                      i_req_ready,
  input  logic                      i_rsp_valid,
  input  logic [(DATW<<P_LOG)-1:0]  i_rsp_data,
  output logic [(DATW<<P_LOG)-1:0]  o_din,
  output logic                      o_dinen,
  output logic [W_LOG-1:0]          o_din_idx,
  output logic                      o_idle,
  output logic                      o_err
`ifdef WAY_REFILL_ARBITER_STAT_EN
  ,
  output logic [31:0]               o_refill_cnt
`endif
);
  localparam int N = 1 << W_LOG;
  localparam int Q = 1 << Q_LOG;
  typedef enum logic {RUN, DRAIN} state_t;
  state_t state;
  logic [N-1:0] pending, elig, set_mask, clr_mask;
  logic [W_LOG-1:0] rr, gnt_idx, k;
  logic gnt_found;
  logic [W_LOG-1:0] fifo [Q];
  logic [Q_LOG-1:0] wp, rp;
  logic [Q_LOG:0] cnt;
  logic full, accept, pop;
  assign full     = cnt == (Q_LOG+1)'(Q);
  assign accept   = o_req_valid && i_req_ready;
  assign pop      = i_rsp_valid && cnt != '0;
  assign elig     = i_emp & ~pending & {N{state == RUN && !full}};
  assign set_mask = accept ? N'(1) << o_req_idx : '0;
  assign clr_mask = o_dinen ? N'(1) << o_din_idx : '0;
  assign o_idle   = state == RUN && cnt == '0 && !o_req_valid;
  // Round-robin search: first eligible way at or after rr, wrapping
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx = rr;
    k = rr;
    for (int i = 0; i < N; i++) begin
      k = rr + W_LOG'(i);
      if (!gnt_found && elig[k]) begin
        gnt_found = 1'b1;
        gnt_idx = k;
      end
    end
  end
  // Index FIFO storage; no reset needed since the pointers define validity
  always_ff @(posedge CLK) begin
    if (accept) fifo[wp] <= o_req_idx;
  end
  // Control state, request channel, FIFO pointers, tree input and error flag
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= RUN;
      o_req_valid <= 1'b0;
      o_req_idx <= '0;
      rr <= '0;
      pending <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      o_dinen <= 1'b0;
      o_din <= '0;
      o_din_idx <= '0;
      o_err <= 1'b0;
    end else begin
      state <= (state == RUN) ? (i_flush ? DRAIN : RUN)
             : ((cnt == '0 && !o_req_valid && !i_flush) ? RUN : DRAIN);
      if (accept) begin
        o_req_valid <= 1'b0;
        rr <= o_req_idx + 1'b1;
        wp <= wp + 1'b1;
      end else if (!o_req_valid && gnt_found) begin
        o_req_valid <= 1'b1;
        o_req_idx <= gnt_idx;
      end
      pending <= (pending & ~clr_mask) | set_mask;
      if (pop) begin
        rp <= rp + 1'b1;
        o_din <= i_rsp_data;
        o_din_idx <= fifo[rp];
      end
      cnt <= cnt + (Q_LOG+1)'(accept) - (Q_LOG+1)'(pop);
      o_dinen <= pop;
      o_err <= o_err || (i_rsp_valid && cnt == '0);
    end
  end
`ifdef WAY_REFILL_ARBITER_STAT_EN
  // Free-running count of refill beats delivered to the tree
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) o_refill_cnt <= '0;
    else if (o_dinen) o_refill_cnt <= o_refill_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_way_refill_arbiter.sv
// tb_way_refill_arbiter: directed vector bench for way_refill_arbiter (4 ways, 16-bit blocks, 2-deep FIFO)
module tb_way_refill_arbiter;
  logic CLK = 1'b0, RST = 1'b0;
  logic [3:0] i_emp = '0;
  logic i_flush = 1'b0, i_req_ready = 1'b0, i_rsp_valid = 1'b0;
  logic [15:0] i_rsp_data = '0;
  logic o_req_valid, o_dinen, o_idle, o_err;
  logic [1:0] o_req_idx, o_din_idx;
  logic [15:0] o_din;
  int checks = 0, errors = 0;

  way_refill_arbiter #(.W_LOG(2), .P_LOG(1), .DATW(8), .Q_LOG(1)) dut (
    .CLK(CLK), .RST(RST), .i_emp(i_emp), .i_flush(i_flush),
    .o_req_valid(o_req_valid), .o_req_idx(o_req_idx), .i_req_ready(i_req_ready),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
    .o_din(o_din), .o_dinen(o_dinen), .o_din_idx(o_din_idx),
    .o_idle(o_idle), .o_err(o_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] emp;
    logic rdy, rv;
    logic [15:0] data;
    logic erv;
    logic [1:0] eidx;
    logic eden;
    logic [15:0] edin;
    logic [1:0] edidx;
    logic eidle, eerr;
  } vec_t;
  vec_t vecs [13];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all(string nm, logic rv, logic [1:0] idx, logic den, logic [15:0] din,
                         logic [1:0] didx, logic idle, logic err);
    chk({nm, ".req_valid"}, 32'(o_req_valid), 32'(rv));
    chk({nm, ".req_idx"}, 32'(o_req_idx), 32'(idx));
    chk({nm, ".dinen"}, 32'(o_dinen), 32'(den));
    chk({nm, ".din"}, 32'(o_din), 32'(din));
    chk({nm, ".din_idx"}, 32'(o_din_idx), 32'(didx));
    chk({nm, ".idle"}, 32'(o_idle), 32'(idle));
    chk({nm, ".err"}, 32'(o_err), 32'(err));
  endtask

  task automatic do_reset;
    RST = 1'b0;
    i_emp = '0; i_flush = 0; i_req_ready = 0; i_rsp_valid = 0; i_rsp_data = '0;
    repeat (2) @(posedge CLK);
    #3 RST = 1'b1;
    tick();
  endtask

  initial begin
    vecs[0]  = '{4'b1010, 1, 0, 16'h0000, 1, 1, 0, 16'h0000, 0, 0, 0};
    vecs[1]  = '{4'b1010, 1, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 0};
    vecs[2]  = '{4'b1010, 1, 0, 16'h0000, 1, 3, 0, 16'h0000, 0, 0, 0};
    vecs[3]  = '{4'b1010, 1, 0, 16'h0000, 0, 3, 0, 16'h0000, 0, 0, 0};
    vecs[4]  = '{4'b1010, 1, 0, 16'h0000, 0, 3, 0, 16'h0000, 0, 0, 0};
    vecs[5]  = '{4'b1010, 1, 1, 16'hA55A, 0, 3, 1, 16'hA55A, 1, 0, 0};
    vecs[6]  = '{4'b1010, 1, 0, 16'h0000, 0, 3, 0, 16'hA55A, 1, 0, 0};
    vecs[7]  = '{4'b1010, 1, 0, 16'h0000, 1, 1, 0, 16'hA55A, 1, 0, 0};
    vecs[8]  = '{4'b1010, 1, 1, 16'h3C3C, 0, 1, 1, 16'h3C3C, 3, 0, 0};
    vecs[9]  = '{4'b1010, 1, 1, 16'h0F0F, 0, 1, 1, 16'h0F0F, 1, 1, 0};
    vecs[10] = '{4'b0000, 1, 0, 16'h0000, 0, 1, 0, 16'h0F0F, 1, 1, 0};
    vecs[11] = '{4'b0000, 1, 1, 16'hFFFF, 0, 1, 0, 16'h0F0F, 1, 1, 1};
    vecs[12] = '{4'b0000, 1, 0, 16'h0000, 0, 1, 0, 16'h0F0F, 1, 1, 1};

    do_reset();
    chk_all("reset", 0, 0, 0, 16'h0000, 0, 1, 0);
    for (int i = 0; i < 13; i++) begin
      i_emp = vecs[i].emp; i_req_ready = vecs[i].rdy;
      i_rsp_valid = vecs[i].rv; i_rsp_data = vecs[i].data;
      tick();
      chk_all($sformatf("v%0d", i), vecs[i].erv, vecs[i].eidx, vecs[i].eden, vecs[i].edin,
              vecs[i].edidx, vecs[i].eidle, vecs[i].eerr);
    end

    // All ways empty, responses 2 cycles after accept: cyclic grant order, no regrant while pending
    do_reset();
    begin
      int n_grant = 0;
      logic [3:0] bp = '0, nbp;
      int due[$];
      logic [1:0] acc_q[$];
      logic [15:0] dat_q[$];
      logic prv = 0, pden = 0;
      logic [1:0] pidx = '0, pdidx = '0;
      i_emp = 4'hF; i_req_ready = 1;
      for (int c = 1; c <= 60; c++) begin
        i_rsp_valid = 0;
        if (due.size() > 0) begin
          if (due[0] == c) begin
            void'(due.pop_front());
            i_rsp_valid = 1;
            i_rsp_data = 16'hB000 + 16'(c);
            dat_q.push_back(i_rsp_data);
          end
        end
        tick();
        if (o_req_valid && !prv) begin
          chk($sformatf("rr_order%0d", n_grant), 32'(o_req_idx), 32'(n_grant % 4));
          chk($sformatf("regrant_pending%0d", n_grant), 32'(bp[o_req_idx]), 32'd0);
          n_grant++;
        end
        nbp = bp;
        if (pden) nbp[pdidx] = 1'b0;
        if (prv) begin
          nbp[pidx] = 1'b1;
          acc_q.push_back(pidx);
          due.push_back(c + 2);
        end
        if (o_dinen) begin
          if (acc_q.size() > 0 && dat_q.size() > 0) begin
            chk("rsp_order_idx", 32'(o_din_idx), 32'(acc_q.pop_front()));
            chk("rsp_data", 32'(o_din), 32'(dat_q.pop_front()));
          end else chk("unexpected_dinen", 32'(o_dinen), 32'd0);
        end
        bp = nbp; prv = o_req_valid; pidx = o_req_idx; pden = o_dinen; pdidx = o_din_idx;
      end
      chk("grant_count_ok", 32'(n_grant >= 8), 32'd1);
    end

    // Held request under backpressure stays stable
    do_reset();
    i_emp = 4'b0100; i_req_ready = 0;
    tick();
    chk("hold_first.valid", 32'(o_req_valid), 32'd1);
    chk("hold_first.idx", 32'(o_req_idx), 32'd2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("hold%0d.valid", i), 32'(o_req_valid), 32'd1);
      chk($sformatf("hold%0d.idx", i), 32'(o_req_idx), 32'd2);
    end
    i_req_ready = 1;
    tick();
    chk("hold_accept.valid", 32'(o_req_valid), 32'd0);
    tick();
    chk("pending_block.valid", 32'(o_req_valid), 32'd0);

    // Flush with two outstanding
    i_emp = 4'b0011;
    tick();
    chk("second_grant.valid", 32'(o_req_valid), 32'd1);
    chk("second_grant.idx", 32'(o_req_idx), 32'd0);
    tick();
    chk("second_accept.valid", 32'(o_req_valid), 32'd0);
    i_flush = 1; i_emp = 4'hF;
    tick();
    chk("drain0.valid", 32'(o_req_valid), 32'd0);
    chk("drain0.idle", 32'(o_idle), 32'd0);
    tick();
    chk("drain1.valid", 32'(o_req_valid), 32'd0);
    i_rsp_valid = 1; i_rsp_data = 16'h1111;
    tick();
    chk_all("drain_rsp0", 0, 0, 1, 16'h1111, 2, 0, 0);
    i_rsp_data = 16'h2222;
    tick();
    chk_all("drain_rsp1", 0, 0, 1, 16'h2222, 0, 0, 0);
    i_rsp_valid = 0;
    tick();
    chk_all("drain_done", 0, 0, 0, 16'h2222, 0, 0, 0);
    i_flush = 0; i_emp = 4'b0000;
    tick();
    chk("drain_exit.idle", 32'(o_idle), 32'd1);
    chk("drain_exit.valid", 32'(o_req_valid), 32'd0);

    // Asynchronous reset with one outstanding and one held request
    i_emp = 4'b0001;
    tick();
    chk("pre_rst_grant.idx", 32'(o_req_idx), 32'd0);
    tick();
    i_emp = 4'b0010;
    tick();
    chk("pre_rst_held.valid", 32'(o_req_valid), 32'd1);
    chk("pre_rst_held.idx", 32'(o_req_idx), 32'd1);
    i_emp = 4'b0000;
    #2 RST = 1'b0;
    #1;
    chk("async_rst.req_valid", 32'(o_req_valid), 32'd0);
    chk("async_rst.req_idx", 32'(o_req_idx), 32'd0);
    chk("async_rst.dinen", 32'(o_dinen), 32'd0);
    chk("async_rst.din", 32'(o_din), 32'd0);
    chk("async_rst.din_idx", 32'(o_din_idx), 32'd0);
    chk("async_rst.err", 32'(o_err), 32'd0);
    #3 RST = 1'b1;
    tick();
    chk("post_rst.idle", 32'(o_idle), 32'd1);
    chk("post_rst.valid", 32'(o_req_valid), 32'd0);
    i_rsp_valid = 1; i_rsp_data = 16'h7777;
    tick();
    chk("stray_rsp.err", 32'(o_err), 32'd1);
    chk("stray_rsp.dinen", 32'(o_dinen), 32'd0);
    i_rsp_valid = 0;
    tick();
    chk("stray_rsp_sticky.err", 32'(o_err), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
